// File: rtl/fetch_queue.sv
// Instruction fetch queue: buffers (pc, inst) pairs between fetch and decode.
// Circular buffer with occupancy count; flush discards all entries.
module fetch_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int INST_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ADDR_W-1:0]        in_pc,
    input  logic [INST_W-1:0]        in_inst,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ADDR_W-1:0]        out_pc,
    output logic [INST_W-1:0]        out_inst,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL = PTR_W'(0) + (PTR_W+1)'(DEPTH);
    localparam logic [INST_W-1:0] NOP = INST_W'(32'h0000_0013);

    logic [ADDR_W-1:0] pc_mem   [DEPTH];
    logic [INST_W-1:0] inst_mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              push;
    logic              pop;

    assign in_ready  = (count != FULL);
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Empty queue presents a NOP at pc 0 rather than stale slot contents.
    assign out_pc   = out_valid ? pc_mem[rd_ptr]   : '0;
    assign out_inst = out_valid ? inst_mem[rd_ptr] : NOP;

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            pc_mem[wr_ptr]   <= in_pc;
            inst_mem[wr_ptr] <= in_inst;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue.
// One task per scenario, each comparing outputs against hand-computed values.
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_inst;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        flush;
    logic [2:0]  count;

    int vectors = 0;
    int miscompares = 0;

    fetch_queue #(.DEPTH(4), .ADDR_W(32), .INST_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_inst   (in_inst),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_inst  (out_inst),
        .flush     (flush),
        .count     (count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mk_inst(input logic [31:0] pc);
        return pc ^ 32'hDEAD_0000;
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
        in_pc     = '0;
        in_inst   = '0;
    endtask

    task automatic push_n(input logic [31:0] base, input int n);
        out_ready = 1'b0;
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_pc    = base + 32'(4 * i);
            in_inst  = mk_inst(in_pc);
            step();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        vectors++;
        if (count !== 3'd0) begin
            miscompares++;
            $display("FAIL reset_count: got %0d want 0", count);
        end
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_hs: in_ready=%b out_valid=%b want 1/0",
                     in_ready, out_valid);
        end
        vectors++;
        if (out_pc !== 32'h0 || out_inst !== 32'h0000_0013) begin
            miscompares++;
            $display("FAIL reset_out: pc=%h inst=%h want 0/00000013",
                     out_pc, out_inst);
        end
    endtask

    task automatic test_fill;
        idle();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_pc    = 32'(4 * i);
            in_inst  = mk_inst(in_pc);
            vectors++;
            if (in_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL fill_ready[%0d]: got %b want 1", i, in_ready);
            end
            step();
        end
        vectors++;
        if (count !== 3'd4 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL fill_full: count=%0d in_ready=%b want 4/0",
                     count, in_ready);
        end
        in_pc   = 32'h10;
        in_inst = mk_inst(in_pc);
        step();
        in_valid = 1'b0;
        vectors++;
        if (count !== 3'd4 || out_pc !== 32'h0) begin
            miscompares++;
            $display("FAIL fill_overflow: count=%0d head=%h want 4/0",
                     count, out_pc);
        end
    endtask

    task automatic test_drain;
        logic [31:0] pc;
        idle();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pc = 32'(4 * i);
            vectors++;
            if (out_valid !== 1'b1 || out_pc !== pc
                || out_inst !== mk_inst(pc)) begin
                miscompares++;
                $display("FAIL drain[%0d]: v=%b pc=%h inst=%h want 1/%h/%h",
                         i, out_valid, out_pc, out_inst, pc, mk_inst(pc));
            end
            step();
        end
        out_ready = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || out_inst !== 32'h0000_0013
            || out_pc !== 32'h0 || count !== 3'd0) begin
            miscompares++;
            $display("FAIL drain_empty: v=%b pc=%h inst=%h cnt=%0d",
                     out_valid, out_pc, out_inst, count);
        end
    endtask

    task automatic test_stream;
        logic [31:0] pc;
        idle();
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_pc   = 32'h100 + 32'(4 * i);
            in_inst = mk_inst(in_pc);
            if (i == 0) begin
                vectors++;
                if (out_valid !== 1'b0) begin
                    miscompares++;
                    $display("FAIL stream_first: out_valid=%b want 0",
                             out_valid);
                end
            end else begin
                pc = 32'h100 + 32'(4 * (i - 1));
                vectors++;
                if (out_valid !== 1'b1 || out_pc !== pc
                    || out_inst !== mk_inst(pc) || count !== 3'd1) begin
                    miscompares++;
                    $display("FAIL stream[%0d]: v=%b pc=%h cnt=%0d want 1/%h/1",
                             i, out_valid, out_pc, count, pc);
                end
            end
            step();
        end
        in_valid = 1'b0;
        vectors++;
        if (out_pc !== 32'h14C || count !== 3'd1) begin
            miscompares++;
            $display("FAIL stream_tail: pc=%h cnt=%0d want 0000014c/1",
                     out_pc, count);
        end
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_flush;
        idle();
        push_n(32'h200, 3);
        vectors++;
        if (count !== 3'd3) begin
            miscompares++;
            $display("FAIL flush_pre: count=%0d want 3", count);
        end
        flush     = 1'b1;
        in_valid  = 1'b1;
        in_pc     = 32'h40;
        in_inst   = mk_inst(in_pc);
        out_ready = 1'b1;
        step();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        vectors++;
        if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL flush_post: cnt=%0d v=%b rdy=%b want 0/0/1",
                     count, out_valid, in_ready);
        end
        in_valid = 1'b1;
        in_pc    = 32'h44;
        in_inst  = mk_inst(in_pc);
        step();
        in_valid = 1'b0;
        vectors++;
        if (out_pc !== 32'h44 || count !== 3'd1) begin
            miscompares++;
            $display("FAIL flush_after: pc=%h cnt=%0d want 00000044/1",
                     out_pc, count);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_full_pop;
        logic [31:0] pc;
        idle();
        push_n(32'h300, 4);
        in_valid  = 1'b1;
        in_pc     = 32'h310;
        in_inst   = mk_inst(in_pc);
        out_ready = 1'b1;
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL fullpop_ready: got %b want 0", in_ready);
        end
        step();
        in_valid = 1'b0;
        vectors++;
        if (count !== 3'd3 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL fullpop_next: cnt=%0d rdy=%b want 3/1",
                     count, in_ready);
        end
        for (int i = 1; i < 4; i++) begin
            pc = 32'h300 + 32'(4 * i);
            vectors++;
            if (out_valid !== 1'b1 || out_pc !== pc) begin
                miscompares++;
                $display("FAIL fullpop_drain[%0d]: v=%b pc=%h want 1/%h",
                         i, out_valid, out_pc, pc);
            end
            step();
        end
        out_ready = 1'b0;
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL fullpop_empty: out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_async_reset;
        idle();
        push_n(32'h500, 2);
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || count !== 3'd0 || out_pc !== 32'h0) begin
            miscompares++;
            $display("FAIL async_rst: v=%b cnt=%0d pc=%h want 0/0/0",
                     out_valid, count, out_pc);
        end
        vectors++;
        if (in_ready !== 1'b1 || out_inst !== 32'h0000_0013) begin
            miscompares++;
            $display("FAIL async_rst_out: rdy=%b inst=%h want 1/00000013",
                     in_ready, out_inst);
        end
        step();
        rst = 1'b0;
        step();
    endtask

    initial begin
        rst = 1'b0;
        idle();
        test_reset();
        test_fill();
        test_drain();
        test_stream();
        test_flush();
        test_full_pop();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
